// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Package name is kept as lc3b_types so existing CPU files keep importing it.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2,
        DONE    = 2'd3
    } lc3b_arb_state;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } lc3b_arb_port;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Grant decision for the arbiter; fixed b-priority, or round-robin with MEM_ARB_ROUND_ROBIN_EN.
// Latency: purely combinational.
// Backpressure: none; the caller only acts on the grant while idle.
module arb_pick
    import lc3b_types::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_port
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_valid = req_a | req_b;
        if (req_a && req_b)
            grant_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
        else
            grant_port = req_a ? PORT_A : PORT_B;
    end
`else
    // Port b always wins a tie, so the last winner is irrelevant here.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = req_a | req_b;
        grant_port  = req_b ? PORT_B : PORT_A;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter (port a = instruction, b = data); MEM_ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: request in IDLE -> pmem strobe next cycle; mem_resp same cycle as pmem_resp, then one DONE bubble.
// Backpressure: requesters hold strobes until their resp; the other port waits in IDLE.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                mem_read_a,
    input  logic                mem_write_a,
    input  logic [ADDR_W-1:0]   mem_address_a,
    input  logic [DATA_W-1:0]   mem_wdata_a,
    input  logic [DATA_W/8-1:0] mem_byte_enable_a,
    output logic                mem_resp_a,
    output logic [DATA_W-1:0]   mem_rdata_a,

    input  logic                mem_read_b,
    input  logic                mem_write_b,
    input  logic [ADDR_W-1:0]   mem_address_b,
    input  logic [DATA_W-1:0]   mem_wdata_b,
    input  logic [DATA_W/8-1:0] mem_byte_enable_b,
    output logic                mem_resp_b,
    output logic [DATA_W-1:0]   mem_rdata_b,

    output logic                pmem_read,
    output logic                pmem_write,
    output logic [ADDR_W-1:0]   pmem_address,
    output logic [DATA_W-1:0]   pmem_wdata,
    output logic [DATA_W/8-1:0] pmem_byte_enable,
    input  logic                pmem_resp,
    input  logic [DATA_W-1:0]   pmem_rdata,

    output logic                busy
);

    lc3b_arb_state state, state_nxt;

    logic req_a, req_b;
    logic grant_valid, grant_port;
    logic last_grant;
    logic take;

    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [DATA_W/8-1:0] cap_be;
    logic                cap_read, cap_write;

    assign req_a = mem_read_a | mem_write_a;
    assign req_b = mem_read_b | mem_write_b;
    assign take  = (state == IDLE) && grant_valid;

    arb_pick u_pick (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= PORT_B;
        else if (take)
            last_grant <= grant_port;
    end
`else
    assign last_grant = PORT_B;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_valid) state_nxt = (grant_port == PORT_A) ? SERVE_A : SERVE_B;
            SERVE_A: if (pmem_resp)   state_nxt = DONE;
            SERVE_B: if (pmem_resp)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are frozen at grant; a write with read also high drops the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            cap_read  <= 1'b0;
            cap_write <= 1'b0;
        end else if (take) begin
            if (grant_port == PORT_A) begin
                cap_addr  <= mem_address_a;
                cap_wdata <= mem_wdata_a;
                cap_be    <= mem_byte_enable_a;
                cap_write <= mem_write_a;
                cap_read  <= mem_read_a & ~mem_write_a;
            end else begin
                cap_addr  <= mem_address_b;
                cap_wdata <= mem_wdata_b;
                cap_be    <= mem_byte_enable_b;
                cap_write <= mem_write_b;
                cap_read  <= mem_read_b & ~mem_write_b;
            end
        end
    end

    always_comb begin
        busy             = (state != IDLE);
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = cap_addr;
        pmem_wdata       = cap_wdata;
        pmem_byte_enable = cap_be;
        mem_resp_a       = 1'b0;
        mem_rdata_a      = '0;
        mem_resp_b       = 1'b0;
        mem_rdata_b      = '0;
        if (state == SERVE_A || state == SERVE_B) begin
            pmem_read  = cap_read;
            pmem_write = cap_write;
        end
        if (state == SERVE_A && pmem_resp) begin
            mem_resp_a  = 1'b1;
            mem_rdata_a = pmem_rdata;
        end
        if (state == SERVE_B && pmem_resp) begin
            mem_resp_b  = 1'b1;
            mem_rdata_b = pmem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; tie expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
    import lc3b_types::*;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read_a, mem_write_a, mem_read_b, mem_write_b;
    logic [AW-1:0] mem_address_a, mem_address_b;
    logic [DW-1:0] mem_wdata_a, mem_wdata_b;
    logic [1:0]    mem_byte_enable_a, mem_byte_enable_b;
    logic          mem_resp_a, mem_resp_b;
    logic [DW-1:0] mem_rdata_a, mem_rdata_b;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [DW-1:0] pmem_wdata, pmem_rdata;
    logic [1:0]    pmem_byte_enable;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read_a        (mem_read_a),
        .mem_write_a       (mem_write_a),
        .mem_address_a     (mem_address_a),
        .mem_wdata_a       (mem_wdata_a),
        .mem_byte_enable_a (mem_byte_enable_a),
        .mem_resp_a        (mem_resp_a),
        .mem_rdata_a       (mem_rdata_a),
        .mem_read_b        (mem_read_b),
        .mem_write_b       (mem_write_b),
        .mem_address_b     (mem_address_b),
        .mem_wdata_b       (mem_wdata_b),
        .mem_byte_enable_b (mem_byte_enable_b),
        .mem_resp_b        (mem_resp_b),
        .mem_rdata_b       (mem_rdata_b),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_byte_enable  (pmem_byte_enable),
        .pmem_resp         (pmem_resp),
        .pmem_rdata        (pmem_rdata),
        .busy              (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    logic exp_tie_a;
    logic [AW-1:0] exp_addr;

    initial begin
        rst = 1'b1;
        {mem_read_a, mem_write_a, mem_read_b, mem_write_b} = '0;
        mem_address_a = '0; mem_wdata_a = '0; mem_byte_enable_a = '0;
        mem_address_b = '0; mem_wdata_b = '0; mem_byte_enable_b = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;

        // Reset state
        tick(); tick();
        settle();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pmem_strobes", 32'({pmem_read, pmem_write}), 0);
        chk("rst_pmem_addr", 32'(pmem_address), 0);
        chk("rst_resp", 32'({mem_resp_a, mem_resp_b}), 0);
        rst = 1'b0;

        // Port a read 0x0040, two wait cycles, data 0x1234
        tick();
        mem_read_a = 1'b1; mem_address_a = 16'h0040;
        settle();
        chk("a_rd_c0_strobe", 32'(pmem_read), 0);
        tick(); settle();
        chk("a_rd_c1_strobe", 32'(pmem_read), 1);
        chk("a_rd_c1_addr", 32'(pmem_address), 32'h0040);
        chk("a_rd_c1_resp", 32'(mem_resp_a), 0);
        tick(); settle();
        chk("a_rd_c2_strobe", 32'(pmem_read), 1);
        tick();
        pmem_resp = 1'b1; pmem_rdata = 16'h1234;
        settle();
        chk("a_rd_c3_strobe", 32'(pmem_read), 1);
        chk("a_rd_c3_resp_a", 32'(mem_resp_a), 1);
        chk("a_rd_c3_rdata", 32'(mem_rdata_a), 32'h1234);
        chk("a_rd_c3_resp_b", 32'(mem_resp_b), 0);
        tick();
        pmem_resp = 1'b0; mem_read_a = 1'b0;
        settle();
        chk("a_rd_done_busy", 32'(busy), 1);
        chk("a_rd_done_resp", 32'(mem_resp_a), 0);
        chk("a_rd_done_strobe", 32'(pmem_read), 0);

        // Port b write 0xBEEF to 0x0102, mask 01, zero-wait memory
        tick();
        mem_write_b = 1'b1; mem_address_b = 16'h0102;
        mem_wdata_b = 16'hBEEF; mem_byte_enable_b = 2'b01;
        settle();
        chk("b_wr_idle_busy", 32'(busy), 0);
        tick();
        pmem_resp = 1'b1; pmem_rdata = 16'h0000;
        settle();
        chk("b_wr_strobes", 32'({pmem_read, pmem_write}), 32'b01);
        chk("b_wr_addr", 32'(pmem_address), 32'h0102);
        chk("b_wr_wdata", 32'(pmem_wdata), 32'hBEEF);
        chk("b_wr_mask", 32'(pmem_byte_enable), 32'b01);
        chk("b_wr_resp", 32'({mem_resp_a, mem_resp_b}), 32'b01);
        tick();
        pmem_resp = 1'b0; mem_write_b = 1'b0;
        settle();
        chk("b_wr_done_busy", 32'(busy), 1);
        chk("b_wr_done_resp", 32'(mem_resp_b), 0);
        tick();
        // Both ports request together for three rounds
        mem_read_a = 1'b1; mem_address_a = 16'h0A00;
        mem_read_b = 1'b1; mem_address_b = 16'h0B00; mem_write_b = 1'b0;
        settle();
        chk("b_wr_idle_busy_after", 32'(busy), 0);
        for (int r = 0; r < 3; r++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_tie_a = (r != 1);
`else
            exp_tie_a = 1'b0;
`endif
            exp_addr = exp_tie_a ? 16'h0A00 : 16'h0B00;
            tick();
            pmem_resp = 1'b1; pmem_rdata = 16'h1000 + 16'(r);
            settle();
            chk($sformatf("tie%0d_addr", r), 32'(pmem_address), 32'(exp_addr));
            chk($sformatf("tie%0d_resp_ab", r), 32'({mem_resp_a, mem_resp_b}),
                exp_tie_a ? 32'b10 : 32'b01);
            tick();
            pmem_resp = 1'b0;
            settle();
            chk($sformatf("tie%0d_done", r), 32'({busy, mem_resp_a, mem_resp_b}), 32'b100);
            tick();
            if (r == 2) begin
                mem_read_a = 1'b0; mem_read_b = 1'b0;
            end
            settle();
            chk($sformatf("tie%0d_idle", r), 32'(busy), 0);
        end

        // Operand change during SERVE_A is ignored
        mem_read_a = 1'b1; mem_address_a = 16'h0010;
        tick();
        mem_address_a = 16'h0020;
        settle();
        chk("hold_addr_c1", 32'(pmem_address), 32'h0010);
        tick(); settle();
        chk("hold_addr_c2", 32'(pmem_address), 32'h0010);
        pmem_resp = 1'b1;
        settle();
        chk("hold_resp", 32'(mem_resp_a), 1);
        tick();
        pmem_resp = 1'b0; mem_read_a = 1'b0;
        tick();

        // Asynchronous reset in the middle of SERVE_B
        mem_read_b = 1'b1; mem_address_b = 16'h0300;
        tick(); settle();
        chk("rst_mid_strobe", 32'(pmem_read), 1);
        pmem_resp = 1'b1; pmem_rdata = 16'hCAFE;
        settle();
        chk("rst_mid_resp_pre", 32'(mem_resp_b), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs",
            32'({busy, pmem_read, pmem_write, mem_resp_a, mem_resp_b}), 0);
        chk("rst_mid_rdata", 32'(mem_rdata_b), 0);
        chk("rst_mid_addr", 32'(pmem_address), 0);
        pmem_resp = 1'b0; mem_read_b = 1'b0;
        tick();
        rst = 1'b0;
        mem_read_a = 1'b1; mem_address_a = 16'h0AAA;
        mem_read_b = 1'b1; mem_address_b = 16'h0BBB;
        tick(); settle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("post_rst_tie_addr", 32'(pmem_address), 32'h0AAA);
`else
        chk("post_rst_tie_addr", 32'(pmem_address), 32'h0BBB);
`endif
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; mem_read_a = 1'b0; mem_read_b = 1'b0;
        tick();

        // Port b read+write together: write wins; pmem_resp in IDLE is ignored
        mem_read_b = 1'b1; mem_write_b = 1'b1; mem_address_b = 16'h0555;
        mem_wdata_b = 16'h5A5A; mem_byte_enable_b = 2'b11;
        tick(); settle();
        chk("rw_strobes", 32'({pmem_read, pmem_write}), 32'b01);
        pmem_resp = 1'b1;
        settle();
        chk("rw_resp", 32'({mem_resp_a, mem_resp_b}), 32'b01);
        tick();
        pmem_resp = 1'b0; mem_read_b = 1'b0; mem_write_b = 1'b0;
        settle();
        chk("rw_done_resp", 32'(mem_resp_b), 0);
        tick();
        pmem_resp = 1'b1;
        settle();
        chk("idle_resp_ignored", 32'({mem_resp_a, mem_resp_b}), 0);
        tick();
        pmem_resp = 1'b0;
        settle();
        chk("idle_stays_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter. It lets the CPU's instruction port (a) and data port (b) share a single physical memory (or unified L2) interface. It sits between the CPU top level and the memory model. It serialises requests under a fixed-priority or round-robin policy and returns each response only to the requester that owns the transaction.

## Interface
- `DATA_W`, default 16: data width of all ports; must be a multiple of 8.
- `ADDR_W`, default 16: address width of all ports.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read_a` / `mem_write_a`  in  1 each  port-a request strobes.
- `mem_address_a`  in  ADDR_W  port-a address.
- `mem_wdata_a`  in  DATA_W  port-a write data.
- `mem_byte_enable_a`  in  DATA_W/8  port-a write byte mask.
- `mem_resp_a`  out  1  port-a completion pulse.
- `mem_rdata_a`  out  DATA_W  port-a read data.
- `mem_*_b`: the same seven signals for port b (data side).
- `pmem_read` / `pmem_write`  out  1 each  downstream request strobes.
- `pmem_address`  out  ADDR_W  downstream address.
- `pmem_wdata`  out  DATA_W  downstream write data.
- `pmem_byte_enable`  out  DATA_W/8  downstream byte mask.
- `pmem_resp`  in  1  downstream completion.
- `pmem_rdata`  in  DATA_W  downstream read data.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: sample requests. A port requests when read or write is high. On any request, grant, capture the port's address, wdata, byte-enable and op into registers, then go to SERVE_A or SERVE_B.
  - SERVE_A / SERVE_B: drive pmem_* from the captured registers and hold them stable until pmem_resp.
    - On pmem_resp, mem_resp_x = 1 combinationally in that cycle, with mem_rdata_x = pmem_rdata. Go to DONE.
  - DONE: one bubble cycle with no outputs asserted, so the requester can drop its strobes. Always go to IDLE.
- Tie in IDLE (both ports requesting): resolved by the arbitration policy (see Configuration).
- A requester must hold its strobes and operands until it sees resp. Changes after the grant are ignored because the operands are captured.
- read and write both high on one port is a protocol error: the write is performed and the read is ignored.
- pmem_resp is ignored in IDLE and DONE.
- Outputs outside their serve state:
  - mem_resp_x = 0 and mem_rdata_x = 0 when not in SERVE_x.
  - pmem_read = 0 and pmem_write = 0 outside SERVE.
  - pmem_address, pmem_wdata and pmem_byte_enable show the captured registers.
- Reset is asynchronous and may arrive mid-transaction:
  - State goes to IDLE and every output is 0.
  - Captured registers go to 0 and last_grant goes to B.
  - An in-flight downstream access is abandoned; the downstream must be reset together with the arbiter.

## Timing
- A request seen in IDLE in cycle 0 gives pmem strobe assertion in cycle 1.
- With pmem_resp in cycle k ≥ 1, mem_resp_x is in cycle k, DONE is cycle k+1, and IDLE is cycle k+2.
- Minimum occupancy with zero-wait memory is 3 cycles per transaction: IDLE, SERVE, DONE.
- Back-to-back: a request held through DONE is granted in the next IDLE cycle.
- Each transaction produces exactly one mem_resp pulse, one cycle wide.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: the tie goes to the port not granted last. last_grant updates on every grant and resets to B, so port a wins the first tie.
- Not defined: port b always wins ties and last_grant is not implemented. A port-b request continuously present in IDLE starves port a; this is accepted behaviour.

## Structure
- In `lc3b_types`:
  - `lc3b_arb_state` enum: IDLE, SERVE_A, SERVE_B, DONE.
  - `lc3b_arb_port` enum: PORT_A, PORT_B.
- Existing types `lc3b_word` and `lc3b_mem_wmask` are used when DATA_W = 16.
- One combinational sub-module, `arb_pick`:
  - inputs: req_a, req_b, last_grant;
  - outputs: grant_valid, grant_port;
  - contains the macro-dependent policy.

## Test plan
- Port a alone reads 0x0040, memory returns 0x1234 after 2 wait cycles:
  - pmem_read is high in cycles 1–3 with pmem_address = 0x0040;
  - mem_resp_a pulses in cycle 3 with mem_rdata_a = 0x1234;
  - mem_resp_b stays 0.
- Port b alone writes 0xBEEF to 0x0102 with byte_enable = 2'b01:
  - pmem_write is high with captured wdata and mask;
  - a single mem_resp_b pulse; busy falls 2 cycles after pmem_resp.
- Both ports request in the same cycle, three rounds, each port re-requesting after its resp:
  - round-robin build: grants A, B, A;
  - fixed-priority build: grants B, B, B, with a still pending.
- Port a changes mem_address_a from 0x0010 to 0x0020 while in SERVE_A: pmem_address stays 0x0010 until resp.
- rst asserted in the middle of SERVE_B (asynchronously, between clock edges): all outputs go to 0 immediately, and after release the first tie is granted to A in the round-robin build.
- Port b raises read and write together: only pmem_write is asserted, and one mem_resp_b pulse is returned.
